// File: rtl/wm8731_dac_tx.sv
// wm8731_dac_tx: WM8731 DAC port serialiser, DSP mode A, FPGA master.
// One buffered stereo pair per frame; serial outputs are registered decodes of the frame counter.
module wm8731_dac_tx #(
   parameter int DATA_W     = 24,
   parameter int FRAME_CLKS = 250,
   parameter int BCLK_DIV   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   output logic              bclk,
   output logic              daclrc,
   output logic              dacdat,
   output logic              frame_start,
   output logic              underrun
);
   localparam int SW = 2 * DATA_W;
   localparam int FW = $clog2(FRAME_CLKS);
   localparam int IW = $clog2(SW);
   localparam logic [FW-1:0] LAST = FW'(FRAME_CLKS - 1);

   logic [FW-1:0] fcnt_q, fcnt_d, b, p;
   logic [SW-1:0] shreg_q, shreg_d, buf_q, buf_d;
   logic [IW-1:0] idx;
   logic          buf_valid_q, buf_valid_d;
   logic          bclk_q, bclk_d, daclrc_q, daclrc_d, dacdat_q, dacdat_d;
   logic          frame_start_q, frame_start_d, underrun_q, underrun_d;
   logic          load, accept;

   // Shift register is static for the whole frame; bit b is picked by index instead of shifting.
   always_comb begin
      load          = enable && fcnt_q == LAST;
      accept        = s_valid && !buf_valid_q;
      b             = fcnt_q / FW'(BCLK_DIV);
      p             = fcnt_q % FW'(BCLK_DIV);
      idx           = IW'(SW - int'(b));
      fcnt_d        = !enable ? LAST : (load ? '0 : fcnt_q + 1'b1);
      shreg_d       = load ? (buf_valid_q ? buf_q : '0) : shreg_q;
      buf_d         = accept ? {s_left, s_right} : buf_q;
      buf_valid_d   = accept || (buf_valid_q && !load);
      bclk_d        = enable && p >= FW'(BCLK_DIV / 2);
      daclrc_d      = enable && b == '0;
      dacdat_d      = enable && b != '0 && int'(b) <= SW && shreg_q[idx];
      frame_start_d = enable && fcnt_q == '0;
      underrun_d    = load && !buf_valid_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q        <= LAST;
         shreg_q       <= '0;
         buf_q         <= '0;
         buf_valid_q   <= 1'b0;
         bclk_q        <= 1'b0;
         daclrc_q      <= 1'b0;
         dacdat_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         fcnt_q        <= fcnt_d;
         shreg_q       <= shreg_d;
         buf_q         <= buf_d;
         buf_valid_q   <= buf_valid_d;
         bclk_q        <= bclk_d;
         daclrc_q      <= daclrc_d;
         dacdat_q      <= dacdat_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign s_ready     = ~buf_valid_q;
   assign bclk        = bclk_q;
   assign daclrc      = daclrc_q;
   assign dacdat      = dacdat_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
endmodule

// File: tb/tb_wm8731_dac_tx.sv
// tb_wm8731_dac_tx: directed checks of the WM8731 DAC serialiser with default parameters
// (24-bit samples, 250 clk frames, BCLK = clk/2).
module tb_wm8731_dac_tx;
   logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, s_valid = 1'b0;
   logic [23:0] s_left = '0, s_right = '0;
   logic        s_ready, bclk, daclrc, dacdat, frame_start, underrun;
   int          total = 0, bad = 0, hs = 0, n = 0;
   logic        stream = 1'b0, prev_dat = 1'b0;

   wm8731_dac_tx dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
      .s_left(s_left), .s_right(s_right), .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat),
      .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {bclk, daclrc, dacdat, frame_start, underrun};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; a streaming source presents the next pair right after each handshake.
   task automatic tick();
      logic acc;
      acc      = s_valid && s_ready;
      prev_dat = dacdat;
      @(posedge clk);
      #1;
      if (acc) begin
         hs++;
         if (stream) begin
            n++;
            s_left  = 24'h100000 + 24'(n);
            s_right = 24'h200000 + 24'(n);
         end else s_valid = 1'b0;
      end
   endtask

   // Sample k=0 follows the load edge; sample k shows the decode of fcnt=k-1.
   task automatic run_frame(input string tag, input logic [47:0] exp_word, input logic exp_ur,
                            input int push_k, input logic [23:0] pl, input logic [23:0] pr);
      logic [47:0] word;
      int          lrc, fs, bc, stray, unstable;
      logic        ur, lrc1, fs1;
      word = '0; lrc = 0; fs = 0; bc = 0; stray = 0; unstable = 0; ur = 0; lrc1 = 0; fs1 = 0;
      for (int k = 0; k < 250; k++) begin
         tick();
         if (k == 0) ur = underrun;
         if (k == 1) begin
            lrc1 = daclrc;
            fs1  = frame_start;
         end
         lrc += daclrc ? 1 : 0;
         fs  += frame_start ? 1 : 0;
         bc  += bclk ? 1 : 0;
         if (k >= 3 && k <= 97 && k % 2 == 1) word = {word[46:0], dacdat};
         if ((k < 3 || k > 98) && dacdat) stray++;
         if (bclk && dacdat !== prev_dat) unstable++;
         if (k == push_k) begin
            s_valid = 1'b1;
            s_left  = pl;
            s_right = pr;
         end
      end
      check($sformatf("%s word", tag), word, exp_word);
      check($sformatf("%s underrun", tag), ur, exp_ur);
      check($sformatf("%s lrc_pos", tag), lrc1, 1);
      check($sformatf("%s lrc_len", tag), lrc, 2);
      check($sformatf("%s fs_pos", tag), fs1, 1);
      check($sformatf("%s fs_cnt", tag), fs, 1);
      check($sformatf("%s bclk_hi", tag), bc, 125);
      check($sformatf("%s stray", tag), stray, 0);
      check($sformatf("%s stable", tag), unstable, 0);
   endtask

   initial begin
      int hs0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst outs", outs(), 0);
      check("rst ready", s_ready, 1);
      rst_n = 1'b1;
      // test 1: preload a pair, then enable
      s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h5A5A5A;
      tick();
      check("t1 ready", s_ready, 0);
      repeat (2) tick();
      check("t1 idle", outs(), 0);
      enable = 1'b1;
      run_frame("t1", 48'hA5A5A5_5A5A5A, 0, -1, 0, 0);
      // test 3: starvation, then one pair pushed mid-frame
      run_frame("t3a", 48'h0, 1, 100, 24'h123456, 24'hFEDCBA);
      run_frame("t3b", 48'h123456_FEDCBA, 0, -1, 0, 0);
      run_frame("t3c", 48'h0, 1, -1, 0, 0);
      // test 4: handshake lands exactly on the load cycle
      s_valid = 1'b1; s_left = 24'h0F0F0F; s_right = 24'hF0F0F0;
      run_frame("t4a", 48'h0, 1, -1, 0, 0);
      check("t4 ready", s_ready, 0);
      run_frame("t4b", 48'h0F0F0F_F0F0F0, 0, -1, 0, 0);
      // test 2: continuous source for 100 frames
      stream = 1'b1; n = 0;
      run_frame("t2 pre", 48'h0, 1, 50, 24'h100000, 24'h200000);
      hs0 = hs;
      for (int i = 0; i < 100; i++)
         run_frame($sformatf("t2 f%0d", i), {24'h100000 + 24'(i), 24'h200000 + 24'(i)}, 0, -1, 0, 0);
      check("t2 handshakes", hs - hs0, 100);
      stream = 1'b0; s_valid = 1'b0;
      // test 5: abort at b=10 with a pair buffered, then re-enable
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 0) check("t5 underrun", underrun, 0);
         if (k == 1) check("t5 lrc", daclrc, 1);
         if (k == 5) begin
            s_valid = 1'b1; s_left = 24'h13579B; s_right = 24'h2468AC;
         end
      end
      enable = 1'b0;
      tick();
      check("t5 off outs", outs(), 0);
      check("t5 off ready", s_ready, 0);
      repeat (3) tick();
      check("t5 idle outs", outs(), 0);
      enable = 1'b1;
      run_frame("t5 reen", 48'h13579B_2468AC, 0, -1, 0, 0);
      // test 6: async reset mid-frame with the buffer full
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k == 5) begin
            s_valid = 1'b1; s_left = 24'h777777; s_right = 24'h888888;
         end
      end
      check("t6 full", s_ready, 0);
      #3 rst_n = 1'b0;
      #1;
      check("t6 rst outs", outs(), 0);
      check("t6 rst ready", s_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_frame("t6 post", 48'h0, 1, -1, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
